// File: rtl/swt16_pkg.sv
// Shared definitions for the SWT16 fetch path: prefetch FSM encoding and
// default fetch constants.
package swt16_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    REDIR = 2'd2
  } swt16_state_e;

  localparam int unsigned SWT16_PC_INCREMENT = 2;
  localparam int unsigned SWT16_RESET_PC     = 0;

endpackage

// File: rtl/swt16_prefetch_if.sv
// Prefetch bus: EX redirect/flush, decoder stall, PMEM read port and the
// queue head presented to decode.
interface swt16_prefetch_if #(
  parameter int unsigned PC_WIDTH        = 12,
  parameter int unsigned PMEM_WORD_WIDTH = 16,
  parameter int unsigned DEPTH           = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                       in_set_pc;
  logic [PC_WIDTH-1:0]        in_branch_pc;
  logic                       in_flush;
  logic                       in_stall;
  logic [PMEM_WORD_WIDTH-1:0] in_pmem_word;
  logic [PC_WIDTH-1:0]        out_pmem_addr;
  logic                       out_pmem_req;
  logic                       out_valid;
  logic [PMEM_WORD_WIDTH-1:0] out_instr;
  logic [PC_WIDTH-1:0]        out_pc;
  logic [CNT_W-1:0]           out_count;

  modport master (
    output in_set_pc, in_branch_pc, in_flush, in_stall, in_pmem_word,
    input  out_pmem_addr, out_pmem_req, out_valid, out_instr, out_pc, out_count
  );

  modport slave (
    input  in_set_pc, in_branch_pc, in_flush, in_stall, in_pmem_word,
    output out_pmem_addr, out_pmem_req, out_valid, out_instr, out_pc, out_count
  );

endinterface

// File: rtl/swt16_fifo.sv
// Circular instruction queue with wrapping pointers and a synchronous clear.
// Push on full (without a same-cycle pop) and pop on empty are ignored.
module swt16_fifo #(
  parameter int unsigned WIDTH = 28,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    empty    = (count_q == '0);
    do_pop   = pop & ~empty & ~clear;
    do_push  = push & ~clear & ((count_q != (AW+1)'(DEPTH)) | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/swt16_prefetch.sv
// SWT16 instruction prefetcher: BOOT/RUN/REDIR fetch FSM feeding a DEPTH-entry
// queue. Define SWT16_PREFETCH_BYPASS_EN to present an arriving word directly.
module swt16_prefetch
  import swt16_pkg::*;
#(
  parameter int unsigned PC_WIDTH        = 12,
  parameter int unsigned PMEM_WORD_WIDTH = 16,
  parameter int unsigned PC_INCREMENT    = SWT16_PC_INCREMENT,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned RESET_PC        = SWT16_RESET_PC
) (
  input  logic            clock,
  input  logic            reset,
  swt16_prefetch_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W = PC_WIDTH + PMEM_WORD_WIDTH;
  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(PC_INCREMENT);
  localparam logic [PC_WIDTH-1:0] PC_RST  = PC_WIDTH'(RESET_PC);

  swt16_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] infl_pc_q, infl_pc_d;
  logic                infl_q, infl_d;

  logic                clear, issue, push, pop;
  logic                fifo_push, fifo_pop, fifo_empty;
  logic [ENT_W-1:0]    resp_entry, fifo_rdata, head_entry;
  logic [CNT_W-1:0]    fifo_count;
  logic [CNT_W:0]      occupancy;
  logic                head_valid;

  always_comb begin
    clear      = bus.in_set_pc | bus.in_flush;
    resp_entry = {infl_pc_q, bus.in_pmem_word};
    push       = infl_q & ~clear;
    // A clearing cycle empties both queue and in-flight slot, so it may refill at once.
    occupancy  = clear ? '0 : ({1'b0, fifo_count} + (CNT_W+1)'(infl_q));
    issue      = reset & ~bus.in_set_pc & (occupancy < (CNT_W+1)'(DEPTH));
`ifdef SWT16_PREFETCH_BYPASS_EN
    head_valid = ~fifo_empty | push;
    head_entry = fifo_empty ? resp_entry : fifo_rdata;
`else
    head_valid = ~fifo_empty;
    head_entry = fifo_rdata;
`endif
    pop        = head_valid & ~bus.in_stall & ~clear;
    fifo_pop   = pop & ~fifo_empty;
`ifdef SWT16_PREFETCH_BYPASS_EN
    // A bypassed word consumed in its arrival cycle never enters storage.
    fifo_push  = push & ~(fifo_empty & pop);
`else
    fifo_push  = push;
`endif
  end

  always_comb begin
    pc_d      = pc_q;
    infl_d    = issue;
    infl_pc_d = pc_q;
    state_d   = state_q;
    if (bus.in_set_pc) pc_d = bus.in_branch_pc;
    else if (issue)    pc_d = pc_q + PC_STEP;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      REDIR:   state_d = RUN;
      default: state_d = BOOT;
    endcase
    if (bus.in_set_pc) state_d = REDIR;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= BOOT;
      pc_q      <= PC_RST;
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      infl_q    <= infl_d;
      infl_pc_q <= infl_pc_d;
    end
  end

  swt16_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .push  (fifo_push),
    .wdata (resp_entry),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  always_comb begin
    bus.out_pmem_addr = pc_q;
    bus.out_pmem_req  = issue;
    bus.out_valid     = head_valid;
    bus.out_instr     = head_valid ? head_entry[PMEM_WORD_WIDTH-1:0] : '0;
    bus.out_pc        = head_valid ? head_entry[ENT_W-1:PMEM_WORD_WIDTH] : '0;
    bus.out_count     = fifo_count;
  end

endmodule

// File: tb/tb_swt16_prefetch.sv
// Directed bench for swt16_prefetch: sequential fetch, stall fill, redirect,
// flush, PC wrap and asynchronous reset mid-stream.
module tb_swt16_prefetch;
  localparam int unsigned PCW   = 12;
  localparam int unsigned WW    = 16;
  localparam int unsigned DEPTH = 4;
`ifdef SWT16_PREFETCH_BYPASS_EN
  localparam int unsigned LAT = 1;
`else
  localparam int unsigned LAT = 2;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n;

  swt16_prefetch_if #(.PC_WIDTH(PCW), .PMEM_WORD_WIDTH(WW), .DEPTH(DEPTH)) bus ();

  swt16_prefetch #(
    .PC_WIDTH        (PCW),
    .PMEM_WORD_WIDTH (WW),
    .PC_INCREMENT    (2),
    .DEPTH           (DEPTH),
    .RESET_PC        (0)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [WW-1:0] word_at(input logic [PCW-1:0] a);
    return {4'hC, a};
  endfunction

  // PMEM model: one-cycle read latency
  always @(posedge clock) bus.in_pmem_word <= word_at(bus.out_pmem_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [PCW-1:0] pc);
    check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check_eq({tag, "_pc"},    32'(bus.out_pc),    32'(pc));
    check_eq({tag, "_instr"}, 32'(bus.out_instr), 32'(word_at(pc)));
  endtask

  task automatic wait_valid(output int unsigned cycles);
    cycles = 0;
    while (bus.out_valid !== 1'b1 && cycles < 8) begin
      step();
      cycles++;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_valid"}, 32'(bus.out_valid),     32'd0);
    check_eq({tag, "_count"}, 32'(bus.out_count),     32'd0);
    check_eq({tag, "_req"},   32'(bus.out_pmem_req),  32'd0);
    check_eq({tag, "_addr"},  32'(bus.out_pmem_addr), 32'h000);
    check_eq({tag, "_instr"}, 32'(bus.out_instr),     32'd0);
    check_eq({tag, "_pc"},    32'(bus.out_pc),        32'd0);
  endtask

  // Leaves the bench 1 time unit into the BOOT cycle.
  task automatic do_reset(input logic stall);
    reset            = 1'b0;
    bus.in_set_pc    = 1'b0;
    bus.in_branch_pc = '0;
    bus.in_flush     = 1'b0;
    bus.in_stall     = stall;
    step();
    step();
    check_reset_state("rst");
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_eq("boot_addr", 32'(bus.out_pmem_addr), 32'h000);
    check_eq("boot_req",  32'(bus.out_pmem_req),  32'd1);
    check_eq("boot_valid", 32'(bus.out_valid),    32'd0);
  endtask

  initial begin
    // Sequential fetch from RESET_PC, no stall
    do_reset(1'b0);
    for (int k = 1; k <= 7; k++) begin
      step();
      check_eq("seq_addr", 32'(bus.out_pmem_addr), 32'(2 * k));
      check_eq("seq_req",  32'(bus.out_pmem_req),  32'd1);
      if (k >= int'(LAT)) check_head("seq", PCW'(2 * (k - int'(LAT))));
      else                check_eq("seq_early_valid", 32'(bus.out_valid), 32'd0);
      if (k >= 2)         check_eq("seq_count", 32'(bus.out_count), (LAT == 2) ? 32'd1 : 32'd0);
    end

    // Stall from release: queue saturates, nothing lost afterwards
    do_reset(1'b1);
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k >= 4) check_eq("full_req", 32'(bus.out_pmem_req), 32'd0);
    end
    check_eq("full_count", 32'(bus.out_count),     32'(DEPTH));
    check_eq("full_addr",  32'(bus.out_pmem_addr), 32'h008);
    check_head("full_head", 12'h000);
    bus.in_stall = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      check_head("drain", PCW'(2 * i));
    end

    // Redirect while full: squashed old words never appear
    bus.in_stall = 1'b1;
    for (int k = 0; k < 10; k++) step();
    check_eq("refill_count", 32'(bus.out_count), 32'(DEPTH));
    bus.in_set_pc    = 1'b1;
    bus.in_branch_pc = 12'h100;
    #1;
    check_eq("setpc_req", 32'(bus.out_pmem_req), 32'd0);
    step();
    bus.in_set_pc = 1'b0;
    bus.in_stall  = 1'b0;
    #1;
    check_eq("redir_valid", 32'(bus.out_valid),     32'd0);
    check_eq("redir_count", 32'(bus.out_count),     32'd0);
    check_eq("redir_addr",  32'(bus.out_pmem_addr), 32'h100);
    check_eq("redir_req",   32'(bus.out_pmem_req),  32'd1);
    wait_valid(n);
    check_eq("redir_lat", n, LAT);
    check_head("redir_first", 12'h100);
    for (int i = 1; i <= 4; i++) begin
      step();
      check_head("redir_seq", PCW'(12'h100 + 2 * i));
    end

    // Flush and redirect together: redirect wins
    bus.in_flush     = 1'b1;
    bus.in_set_pc    = 1'b1;
    bus.in_branch_pc = 12'h200;
    step();
    bus.in_flush  = 1'b0;
    bus.in_set_pc = 1'b0;
    #1;
    check_eq("both_valid", 32'(bus.out_valid),     32'd0);
    check_eq("both_addr",  32'(bus.out_pmem_addr), 32'h200);
    wait_valid(n);
    check_eq("both_lat", n, LAT);
    check_head("both_first", 12'h200);
    step();
    check_head("both_next", 12'h202);

    // Flush alone at fetch PC 0x00A: fetch PC kept
    do_reset(1'b0);
    for (int k = 1; k <= 5; k++) step();
    check_eq("preflush_addr", 32'(bus.out_pmem_addr), 32'h00A);
    bus.in_flush = 1'b1;
    step();
    bus.in_flush = 1'b0;
    #1;
    check_eq("flush_count", 32'(bus.out_count),     32'd0);
    check_eq("flush_addr",  32'(bus.out_pmem_addr), 32'h00C);
    wait_valid(n);
    check_head("flush_first", 12'h00A);
    step();
    check_head("flush_next", 12'h00C);

    // PC wrap from 0xFFE
    bus.in_set_pc    = 1'b1;
    bus.in_branch_pc = 12'hFFE;
    step();
    bus.in_set_pc = 1'b0;
    #1;
    check_eq("wrap_addr0", 32'(bus.out_pmem_addr), 32'hFFE);
    step();
    check_eq("wrap_addr1", 32'(bus.out_pmem_addr), 32'h000);
    check_eq("wrap_req",   32'(bus.out_pmem_req),  32'd1);
    wait_valid(n);
    check_head("wrap_first", 12'hFFE);
    step();
    check_head("wrap_next", 12'h000);

    // Asynchronous reset with three entries queued
    do_reset(1'b1);
    for (int k = 1; k <= 4; k++) step();
    check_eq("prerst_count", 32'(bus.out_count), 32'd3);
    reset = 1'b0;
    #1;
    check_reset_state("async_rst");
    bus.in_stall = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_eq("restart_addr", 32'(bus.out_pmem_addr), 32'h000);
    check_eq("restart_req",  32'(bus.out_pmem_req),  32'd1);
    wait_valid(n);
    check_eq("restart_lat", n, LAT);
    check_head("restart_first", 12'h000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
